mesh_job_scheduler: RTL and testbench

//  Sequences one matrix-vector job on the 2-D mesh: streams ROWS*COLS weights into the mesh

---
 rtl/mesh_job_scheduler_pkg.sv | 29 ++
 rtl/mesh_job_scheduler_if.sv | 47 ++++
 rtl/mesh_job_scheduler_cfg_addr_gen.sv | 43 ++++
 rtl/mesh_job_scheduler.sv | 136 +++++++++++++
 tb/tb_mesh_job_scheduler.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mesh_job_scheduler_pkg.sv
// Shared types and constants for the mesh job scheduler.
// Optional weight reuse is enabled by defining MESH_SCHED_REUSE_EN.
package mesh_sched_pkg;

  localparam int DW         = 8;
  localparam int ROWS       = 32;
  localparam int COLS       = 32;
  localparam int ROW_W      = 5;
  localparam int COL_W      = 5;
  localparam int ACC_W      = 16;
  localparam int RUN_CYCLES = ROWS + COLS + 2;
  localparam int RUN_W      = 7;
  localparam int AW         = ROW_W + COL_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT_X = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Mesh preload address is the row index above the column index.
  function automatic logic [AW-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/mesh_job_scheduler_if.sv
// Host-side job/weight/vector/result streams plus the mesh-facing pins.
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// edge where both valid and ready are 1; ready never depends on valid, and the
// producer holds valid and data until that edge.
interface mesh_job_scheduler_if;
  import mesh_sched_pkg::*;

  logic                  job_valid;
  logic                  job_ready;
  logic                  job_reuse;
  logic                  w_valid;
  logic                  w_ready;
  logic [DW-1:0]         w_data;
  logic                  x_valid;
  logic                  x_ready;
  logic [COLS*DW-1:0]    x_data;
  logic                  mesh_cfg_valid;
  logic [AW-1:0]         mesh_cfg_addr;
  logic [DW-1:0]         mesh_cfg_data;
  logic [COLS*DW-1:0]    mesh_x_vector;
  logic                  mesh_start;
  logic [ROWS*ACC_W-1:0] mesh_result;
  logic                  res_valid;
  logic                  res_ready;
  logic [ROWS*ACC_W-1:0] res_data;
  logic                  busy;
  logic                  weights_loaded;

  // Scheduler side
  modport slave (
    input  job_valid, job_reuse, w_valid, w_data, x_valid, x_data,
           mesh_result, res_ready,
    output job_ready, w_ready, x_ready, mesh_cfg_valid, mesh_cfg_addr,
           mesh_cfg_data, mesh_x_vector, mesh_start, res_valid, res_data,
           busy, weights_loaded
  );

  // Host + mesh side
  modport master (
    output job_valid, job_reuse, w_valid, w_data, x_valid, x_data,
           mesh_result, res_ready,
    input  job_ready, w_ready, x_ready, mesh_cfg_valid, mesh_cfg_addr,
           mesh_cfg_data, mesh_x_vector, mesh_start, res_valid, res_data,
           busy, weights_loaded
  );

endinterface

// File: rtl/mesh_job_scheduler_cfg_addr_gen.sv
// Row-major {row,col} walker for the weight preload stream.
// o_last marks the final cell of the mesh so the caller can leave LOAD.
module mesh_cfg_addr_gen
  import mesh_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_adv,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  // Column advances per accepted beat, wrapping into the next row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = (r_row == ROW_MAX) && (r_col == COL_MAX);

endmodule

// File: rtl/mesh_job_scheduler.sv
// Sequences one matrix-vector job: weight preload, vector latch, mesh start,
// fixed compute window, result capture and hand-off.
// Define MESH_SCHED_REUSE_EN to let job_reuse skip the preload when a full
// weight set is already resident.
module mesh_job_scheduler
  import mesh_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mesh_job_scheduler_if.slave bus,
  output state_t              o_state
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_job_ready;
  logic                  r_cfg_valid;
  logic [AW-1:0]         r_cfg_addr;
  logic [DW-1:0]         r_cfg_data;
  logic [COLS*DW-1:0]    r_x_vec;
  logic                  r_start;
  logic [RUN_W-1:0]      r_run_cnt;
  logic [ROWS*ACC_W-1:0] r_res;
  logic                  r_loaded;

  logic                  w_job_acc;
  logic                  w_w_acc;
  logic                  w_x_acc;
  logic                  w_run_last;
  logic                  w_skip_load;
  logic                  w_load_clear;
  logic                  w_last_beat;
  logic [ROW_W-1:0]      w_row;
  logic [COL_W-1:0]      w_col;
  logic                  w_addr_last;

  assign w_job_acc   = bus.job_valid && r_job_ready;
  assign w_w_acc     = bus.w_valid && (r_state == LOAD);
  assign w_x_acc     = bus.x_valid && (r_state == WAIT_X);
  assign w_run_last  = (r_state == RUN) && (r_run_cnt == RUN_W'(RUN_CYCLES - 1));
`ifdef MESH_SCHED_REUSE_EN
  assign w_skip_load = bus.job_reuse && r_loaded;
`else
  assign w_skip_load = 1'b0;
`endif
  assign w_load_clear = w_job_acc && !w_skip_load;
  assign w_last_beat  = w_w_acc && w_addr_last;

  mesh_cfg_addr_gen u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_load_clear),
    .i_adv   (w_w_acc),
    .o_row   (w_row),
    .o_col   (w_col),
    .o_last  (w_addr_last)
  );

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_job_acc)     w_next = w_skip_load ? WAIT_X : LOAD;
      LOAD:    if (w_last_beat)   w_next = WAIT_X;
      WAIT_X:  if (w_x_acc)       w_next = RUN;
      RUN:     if (w_run_last)    w_next = DONE;
      DONE:    if (bus.res_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  // State register; job_ready is registered so it stays low through reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_job_ready <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_job_ready <= (w_next == IDLE);
    end
  end

  // Datapath: cfg strobe one cycle after each beat, weight-resident flag,
  // vector latch, start pulse, compute-window counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_valid <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_loaded    <= 1'b0;
      r_x_vec     <= '0;
      r_start     <= 1'b0;
      r_run_cnt   <= '0;
      r_res       <= '0;
    end else begin
      r_cfg_valid <= w_w_acc;
      if (w_w_acc) begin
        r_cfg_addr <= pack_addr(w_row, w_col);
        r_cfg_data <= bus.w_data;
      end
      if (w_load_clear) begin
        r_loaded <= 1'b0;
      end else if (w_last_beat) begin
        r_loaded <= 1'b1;
      end
      if (w_x_acc) begin
        r_x_vec <= bus.x_data;
      end
      r_start <= w_x_acc;
      if (w_x_acc) begin
        r_run_cnt <= '0;
      end else if (r_state == RUN) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
      if (w_run_last) begin
        r_res <= bus.mesh_result;
      end
    end
  end

  assign bus.job_ready      = r_job_ready;
  assign bus.w_ready        = (r_state == LOAD);
  assign bus.x_ready        = (r_state == WAIT_X);
  assign bus.mesh_cfg_valid = r_cfg_valid;
  assign bus.mesh_cfg_addr  = r_cfg_addr;
  assign bus.mesh_cfg_data  = r_cfg_data;
  assign bus.mesh_x_vector  = r_x_vec;
  assign bus.mesh_start     = r_start;
  assign bus.res_valid      = (r_state == DONE);
  assign bus.res_data       = r_res;
  assign bus.busy           = (r_state != IDLE);
  assign bus.weights_loaded = r_loaded;
  assign o_state            = r_state;

endmodule

// File: tb/tb_mesh_job_scheduler.sv
// Self-checking bench for mesh_job_scheduler (optionally with MESH_SCHED_REUSE_EN).
module tb_mesh_job_scheduler;
  import mesh_sched_pkg::*;

`ifdef MESH_SCHED_REUSE_EN
  localparam bit REUSE_ON = 1'b1;
`else
  localparam bit REUSE_ON = 1'b0;
`endif
  localparam int NW       = ROWS * COLS;
  localparam int LAT_LOAD = 1 + NW + 1 + RUN_CYCLES;  // accept -> first DONE cycle
  localparam int LAT_SKIP = 1 + RUN_CYCLES + 1;
  localparam int XW       = COLS * DW;
  localparam int RW       = ROWS * ACC_W;

  typedef struct {
    bit reuse;
    int stall;    // percent of cycles with w_valid low
    bit x_early;  // x_valid raised at job accept
    int hold;     // cycles res_ready stays low in DONE
    bit pat;      // 1: w=(r+c)&0x7F and x=all ones
    int beats;    // expected cfg strobes
    int lat;      // expected accept->res_valid cycles, 0 = not checked
  } job_vec_t;

  logic clk;
  logic rst;
  state_t dbg_state;
  mesh_job_scheduler_if bus();

  mesh_job_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cfg_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  bit model_loaded = 1'b0;
  logic [XW-1:0] prev_x = '0;
  logic [DW-1:0] wmem [NW];
  logic [AW+DW-1:0] exp_q[$];
  job_vec_t tbl [5];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_wide();
    logic [RW-1:0] v;
    for (int i = 0; i < RW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mesh_cfg_valid) begin
        cfg_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cfg_extra act=%0h exp=none", {bus.mesh_cfg_addr, bus.mesh_cfg_data});
        end else begin
          chk("cfg_beat", {bus.mesh_cfg_addr, bus.mesh_cfg_data}, exp_q.pop_front());
        end
      end
      if (bus.mesh_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.job_valid = 0; bus.job_reuse = 0; bus.w_valid = 0; bus.w_data = '0;
    bus.x_valid = 0; bus.x_data = '0; bus.res_ready = 0;
  endtask

  task automatic push_expected();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_q.push_back({pack_addr(ROW_W'(r), COL_W'(c)), wmem[r*COLS + c]});
  endtask

  task automatic run_job(input job_vec_t v);
    logic [XW-1:0] xv;
    logic [RW-1:0] rv;
    int a, budget, idx, starts0;
    bit ok_load, ok_run, ok_hold, vb, acc;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        wmem[r*COLS + c] = v.pat ? DW'((r + c) & 8'h7F) : DW'($urandom_range(255));
    if (v.pat) begin
      for (int c = 0; c < COLS; c++) xv[c*DW +: DW] = 8'd1;
    end else begin
      xv = XW'(rand_wide());
    end
    rv = rand_wide();
    bus.mesh_result = rv;
    if (v.beats != 0) push_expected();
    cfg_cnt = 0;
    starts0 = start_cnt;

    budget = 0;
    while (!bus.job_ready && budget < 20) begin @(negedge clk); budget++; end
    chk("job_ready_wait", bus.job_ready, 1);
    bus.job_valid = 1; bus.job_reuse = v.reuse;
    if (v.x_early) begin bus.x_valid = 1; bus.x_data = xv; end
    a = cyc;
    @(posedge clk); @(negedge clk);
    bus.job_valid = 0; bus.job_reuse = 0;
    chk("job_ready_after_accept", bus.job_ready, 0);
    if (v.beats == 0) begin
      chk("state_after_reuse", dbg_state, WAIT_X);
      chk("x_ready_after_reuse", bus.x_ready, 1);
    end else begin
      chk("state_after_accept", dbg_state, LOAD);
      chk("w_ready_after_accept", bus.w_ready, 1);
    end

    idx = 0; budget = 0; ok_load = 1;
    while (v.beats != 0 && idx < NW && budget < 20000) begin
      vb = ($urandom_range(99) >= v.stall);
      bus.w_valid = vb; bus.w_data = wmem[idx];
      if (v.x_early && bus.x_ready) ok_load = 0;
      if (bus.mesh_x_vector !== prev_x) ok_load = 0;
      acc = vb && bus.w_ready;
      @(posedge clk); @(negedge clk);
      if (acc) idx++;
      budget++;
    end
    bus.w_valid = 0;
    if (v.beats != 0) begin
      chk("load_beats", idx, NW);
      if (v.x_early) chk("x_blocked_in_load", ok_load, 1);
    end
    chk("weights_loaded", bus.weights_loaded, 1);

    bus.x_valid = 1; bus.x_data = xv; budget = 0;
    while (!bus.x_ready && budget < 20) begin @(negedge clk); budget++; end
    chk("x_ready_wait", bus.x_ready, 1);
    @(posedge clk); @(negedge clk);
    bus.x_data = ~xv;
    budget = 0; ok_run = 1;
    while (!bus.res_valid && budget < 200) begin
      if (bus.x_ready) ok_run = 0;
      @(negedge clk);
      budget++;
    end
    bus.x_valid = 0;
    chk("res_valid_seen", bus.res_valid, 1);
    if (v.lat != 0) chk("job_latency", cyc - a, v.lat);
    chk("start_pulses", start_cnt - starts0, 1);
    chk("start_to_res", cyc - start_cyc, RUN_CYCLES);
    chk("res_data", bus.res_data, rv);
    chk("x_vector_latched", bus.mesh_x_vector, xv);
    chk("x_blocked_in_run", ok_run, 1);

    ok_hold = 1;
    for (int h = 0; h < v.hold; h++) begin
      if (!bus.res_valid || bus.res_data !== rv || bus.job_ready || !bus.busy) ok_hold = 0;
      @(negedge clk);
    end
    if (v.hold > 0) chk("done_hold_stable", ok_hold, 1);
    bus.res_ready = 1;
    @(posedge clk); @(negedge clk);
    bus.res_ready = 0;
    chk("after_done", {bus.res_valid, bus.job_ready, bus.busy}, 3'b010);
    chk("cfg_count", cfg_cnt, v.beats);
    chk("cfg_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    prev_x = xv;
    model_loaded = 1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    job_vec_t rj;
    int idx, budget;
    bit acc;
    idle_inputs();
    bus.mesh_result = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {bus.job_ready, bus.w_ready, bus.x_ready, bus.mesh_cfg_valid, bus.mesh_start,
         bus.res_valid, bus.busy, bus.weights_loaded, |bus.mesh_cfg_addr,
         |bus.mesh_cfg_data, |bus.mesh_x_vector, |bus.res_data}, 12'h000);
    rst = 0;
    #1 chk("job_ready_in_release_cycle", bus.job_ready, 0);
    @(negedge clk);
    chk("job_ready_after_release", bus.job_ready, 1);
    chk("state_idle", dbg_state, IDLE);

    // Reset in the middle of a preload: 100 beats then abandon.
    for (int k = 0; k < NW; k++) wmem[k] = DW'($urandom_range(255));
    push_expected();
    bus.job_valid = 1;
    @(posedge clk); @(negedge clk);
    bus.job_valid = 0;
    idx = 0; budget = 0;
    while (idx < 100 && budget < 200) begin
      bus.w_valid = 1; bus.w_data = wmem[idx];
      acc = bus.w_ready;
      @(posedge clk); @(negedge clk);
      if (acc) idx++;
      budget++;
    end
    bus.w_valid = 0;
    #2 rst = 1;
    #1;
    chk("midload_beats_seen", exp_q.size(), NW - 100);
    chk("midload_reset_outputs",
        {bus.job_ready, bus.w_ready, bus.x_ready, bus.mesh_cfg_valid, bus.mesh_start,
         bus.res_valid, bus.busy, bus.weights_loaded, |bus.mesh_cfg_addr,
         |bus.mesh_cfg_data}, 10'h000);
    chk("midload_reset_state", dbg_state, IDLE);
    exp_q.delete();
    model_loaded = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Directed table: reuse with nothing loaded, stalls, DONE hold, reuse hits.
    tbl[0] = '{1, 0,  1, 0,  1, NW, LAT_LOAD};
    tbl[1] = '{0, 50, 0, 20, 0, NW, 0};
    tbl[2] = '{1, 0,  1, 0,  0, REUSE_ON ? 0 : NW, REUSE_ON ? LAT_SKIP : LAT_LOAD};
    tbl[3] = '{0, 25, 1, 3,  0, NW, 0};
    tbl[4] = '{1, 0,  0, 5,  0, REUSE_ON ? 0 : NW, REUSE_ON ? LAT_SKIP : LAT_LOAD};
    for (int i = 0; i < 5; i++) run_job(tbl[i]);

    // Randomized jobs; expectations from the reuse/loaded model.
    for (int i = 0; i < 3; i++) begin
      rj.reuse   = 1'($urandom_range(1));
      rj.stall   = (i == 0) ? 0 : $urandom_range(60);
      rj.x_early = 1'($urandom_range(1));
      rj.hold    = $urandom_range(4);
      rj.pat     = 0;
      rj.beats   = (REUSE_ON && rj.reuse && model_loaded) ? 0 : NW;
      if (rj.beats == 0) rj.lat = LAT_SKIP;
      else rj.lat = (rj.stall == 0) ? LAT_LOAD : 0;
      run_job(rj);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
